// File: rtl/dbg_executor.sv
// Debug command executor: runs one decoded command as a single debug-bus access and streams
// a status byte, plus read data for successful READs, to the UART transmitter.
module dbg_executor #(
    parameter int unsigned DatW       = 4,
    parameter int unsigned AdrW       = 4,
    parameter int unsigned BusTimeout = 1024
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic [8*(1+AdrW+DatW)-1:0]   cmd,
    input  logic                         cmd_valid,
    input  logic                         dec_error,
    output logic                         busy,
    output logic                         cmd_dropped,

    output logic                         bus_req,
    output logic                         bus_we,
    output logic [8*AdrW-1:0]            bus_addr,
    output logic [8*DatW-1:0]            bus_wdata,
    input  logic                         bus_ack,
    input  logic                         bus_err,
    input  logic [8*DatW-1:0]            bus_rdata,

    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready
);

    localparam int unsigned AW   = 8 * AdrW;
    localparam int unsigned DW   = 8 * DatW;
    localparam int unsigned CmdW = 8 * (1 + AdrW + DatW);
    localparam int unsigned TmoW = $clog2(BusTimeout);
    localparam int unsigned CntW = (DatW > 1) ? $clog2(DatW) : 1;

    localparam logic [TmoW-1:0] TmoLast  = TmoW'(BusTimeout - 1);
    localparam logic [CntW-1:0] ByteLast = CntW'(DatW - 1);

    localparam logic [7:0] OpRead  = 8'h01;
    localparam logic [7:0] OpWrite = 8'h02;
    localparam logic [7:0] OpPing  = 8'h03;

    localparam logic [7:0] StatOk      = 8'hA0;
    localparam logic [7:0] StatBusErr  = 8'hE1;
    localparam logic [7:0] StatTimeout = 8'hE2;
    localparam logic [7:0] StatBadOp   = 8'hE3;
    localparam logic [7:0] StatDecErr  = 8'hE4;

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StRespStatus,
        StRespData
    } state_e;

    state_e          state;
    logic [7:0]      opcode_q;
    logic [DW-1:0]   rdata_q;
    logic [TmoW-1:0] tmo_cnt;
    logic [CntW-1:0] byte_cnt;

    logic [7:0]      cmd_op;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;
    logic            cmd_is_bus;
    logic [7:0]      rdata_top;

    assign cmd_op     = cmd[CmdW-1 -: 8];
    assign cmd_addr   = cmd[DW +: AW];
    assign cmd_wdata  = cmd[DW-1:0];
    assign cmd_is_bus = (cmd_op == OpRead) || (cmd_op == OpWrite);
    // Read data is shifted left as bytes go out, so the next byte is always on top.
    assign rdata_top  = rdata_q[DW-1 -: 8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            opcode_q    <= '0;
            rdata_q     <= '0;
            tmo_cnt     <= '0;
            byte_cnt    <= '0;
            busy        <= 1'b0;
            cmd_dropped <= 1'b0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    tmo_cnt  <= '0;
                    byte_cnt <= '0;
                    if (dec_error) begin
                        // A decode error discards any command arriving alongside it.
                        opcode_q <= '0;
                        busy     <= 1'b1;
                        tx_valid <= 1'b1;
                        tx_data  <= StatDecErr;
                        state    <= StRespStatus;
                    end else if (cmd_valid) begin
                        opcode_q  <= cmd_op;
                        bus_addr  <= cmd_addr;
                        bus_wdata <= cmd_wdata;
                        bus_we    <= (cmd_op == OpWrite);
                        busy      <= 1'b1;
                        if (cmd_is_bus) begin
                            bus_req <= 1'b1;
                            state   <= StBus;
                        end else begin
                            tx_valid <= 1'b1;
                            tx_data  <= (cmd_op == OpPing) ? StatOk : StatBadOp;
                            state    <= StRespStatus;
                        end
                    end
                end

                StBus: begin
                    if (bus_err || bus_ack || (tmo_cnt == TmoLast)) begin
                        bus_req  <= 1'b0;
                        tx_valid <= 1'b1;
                        state    <= StRespStatus;
                    end
                    if (bus_err) begin
                        tx_data <= StatBusErr;
                    end else if (bus_ack) begin
                        tx_data <= StatOk;
                        if (opcode_q == OpRead) begin
                            rdata_q <= bus_rdata;
                        end
                    end else if (tmo_cnt == TmoLast) begin
                        tx_data <= StatTimeout;
                    end else begin
                        tmo_cnt <= tmo_cnt + TmoW'(1);
                    end
                end

                StRespStatus: begin
                    if (tx_ready) begin
                        if ((opcode_q == OpRead) && (tx_data == StatOk)) begin
                            tx_data  <= rdata_top;
                            rdata_q  <= rdata_q << 8;
                            byte_cnt <= '0;
                            state    <= StRespData;
                        end else begin
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            state    <= StIdle;
                        end
                    end
                end

                StRespData: begin
                    if (tx_ready) begin
                        if (byte_cnt == ByteLast) begin
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            state    <= StIdle;
                        end else begin
                            byte_cnt <= byte_cnt + CntW'(1);
                            tx_data  <= rdata_top;
                            rdata_q  <= rdata_q << 8;
                        end
                    end
                end

                default: begin
                    state <= StIdle;
                end
            endcase

            if ((state != StIdle) && (cmd_valid || dec_error)) begin
                cmd_dropped <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dbg_executor.sv
// Self-checking bench for dbg_executor: table of command vectors with a byte scoreboard,
// plus directed sequences for back-pressure, dropped commands and mid-access reset.
module tb_dbg_executor;

    localparam int unsigned DatW = 4;
    localparam int unsigned AdrW = 4;
    localparam int unsigned Tmo  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [71:0] cmd;
    logic        cmd_valid, dec_error;
    logic        busy, cmd_dropped;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_ack, bus_err;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;

    dbg_executor #(
        .DatW       (DatW),
        .AdrW       (AdrW),
        .BusTimeout (Tmo)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd         (cmd),
        .cmd_valid   (cmd_valid),
        .dec_error   (dec_error),
        .busy        (busy),
        .cmd_dropped (cmd_dropped),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_err     (bus_err),
        .bus_rdata   (bus_rdata),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [7:0]  sb[$];
    int unsigned hs_cyc[$];
    int          hs_total = 0;

    // errm: 0 = plain ack, 1 = bus_err alone, 2 = bus_err together with bus_ack
    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_dly;
        int          errm;
        bit          late_ack;
        logic [7:0]  exp_status;
        int          exp_req;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshakes complete on the next posedge; sample at the negedge before it.
    initial begin
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (!rst && tx_valid && tx_ready) begin
                hs_total++;
                hs_cyc.push_back(cyc);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL tx_extra: got byte %02h, required no byte", tx_data);
                end else begin
                    exp = sb.pop_front();
                    if (tx_data !== exp) begin
                        errors++;
                        $display("FAIL tx_byte: got %02h, required %02h (cycle %0d)",
                                 tx_data, exp, cyc);
                    end
                end
            end
        end
    end

    task automatic push_resp(input logic [7:0] status, input logic [7:0] op,
                             input logic [31:0] rdata, output int n);
        sb.push_back(status);
        n = 1;
        if (op == 8'h01 && status == 8'hA0) begin
            for (int i = 3; i >= 0; i--) begin
                sb.push_back(rdata[8*i +: 8]);
            end
            n = 5;
        end
    endtask

    task automatic send(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit cv, input bit de);
        cmd       = {op, addr, wdata};
        cmd_valid = cv;
        dec_error = de;
        step();
        cmd_valid = 1'b0;
        dec_error = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            step();
            n++;
        end
        chk({name, "_left"}, 64'(sb.size()), 64'd0);
        chk({name, "_busy"}, {63'd0, busy}, 64'd0);
        chk({name, "_txv"}, {63'd0, tx_valid}, 64'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  req = 0;
        bit  bad = 1'b0;
        int  n, n0;
        push_resp(v.exp_status, v.op, v.rdata, n);
        n0 = hs_total;
        send(v.op, v.addr, v.wdata, 1'b1, 1'b0);
        chk($sformatf("v%0d_busy_c1", idx), {63'd0, busy}, 64'd1);
        if (v.exp_req == 0) begin
            chk($sformatf("v%0d_txv_c1", idx), {63'd0, tx_valid}, 64'd1);
        end
        while (bus_req && req < 100) begin
            req++;
            if (bus_we !== (v.op == 8'h02) || bus_addr !== v.addr || bus_wdata !== v.wdata)
                bad = 1'b1;
            if (v.ack_dly >= 0 && req == v.ack_dly + 1) begin
                bus_ack   = (v.errm != 1);
                bus_err   = (v.errm != 0);
                bus_rdata = v.rdata;
            end
            step();
            bus_ack   = 1'b0;
            bus_err   = 1'b0;
            bus_rdata = $urandom;
        end
        chk($sformatf("v%0d_req_cycles", idx), 64'(req), 64'(v.exp_req));
        chk($sformatf("v%0d_bus_stable", idx), {63'd0, bad}, 64'd0);
        if (v.late_ack) begin
            bus_ack   = 1'b1;
            bus_rdata = 32'hBAD0BAD0;
            step();
            step();
            bus_ack   = 1'b0;
            chk($sformatf("v%0d_late_req", idx), {63'd0, bus_req}, 64'd0);
        end
        drain($sformatf("v%0d_drain", idx));
        chk($sformatf("v%0d_nbytes", idx), 64'(hs_total - n0), 64'(n));
        if (n > 1 && hs_cyc.size() >= n) begin
            chk($sformatf("v%0d_b2b", idx),
                64'(hs_cyc[hs_cyc.size()-1] - hs_cyc[hs_cyc.size()-n]), 64'(n - 1));
        end
    endtask

    initial begin
        int  n, n0;
        bit  held;

        vecs.push_back('{op:8'h01, addr:32'h0000_1000, wdata:32'h0, rdata:32'hDEAD_BEEF,
                         ack_dly:3, errm:0, late_ack:0, exp_status:8'hA0, exp_req:4});
        vecs.push_back('{op:8'h02, addr:32'h0000_0010, wdata:32'h1234_5678, rdata:32'h0,
                         ack_dly:0, errm:0, late_ack:0, exp_status:8'hA0, exp_req:1});
        vecs.push_back('{op:8'h01, addr:32'h0000_2000, wdata:32'h0, rdata:32'h1111_1111,
                         ack_dly:-1, errm:0, late_ack:1, exp_status:8'hE2, exp_req:16});
        vecs.push_back('{op:8'h01, addr:32'h0000_3000, wdata:32'h0, rdata:32'h2222_2222,
                         ack_dly:2, errm:2, late_ack:0, exp_status:8'hE1, exp_req:3});
        vecs.push_back('{op:8'h7F, addr:32'h0000_0050, wdata:32'h0, rdata:32'h0,
                         ack_dly:0, errm:0, late_ack:0, exp_status:8'hE3, exp_req:0});
        vecs.push_back('{op:8'h03, addr:32'h0, wdata:32'h0, rdata:32'h0,
                         ack_dly:0, errm:0, late_ack:0, exp_status:8'hA0, exp_req:0});
        vecs.push_back('{op:8'h02, addr:32'h0000_0040, wdata:32'hA5A5_5A5A, rdata:32'h0,
                         ack_dly:0, errm:1, late_ack:0, exp_status:8'hE1, exp_req:1});
        vecs.push_back('{op:8'h01, addr:32'hABCD_0000, wdata:32'h0, rdata:32'h0102_A5FF,
                         ack_dly:0, errm:0, late_ack:0, exp_status:8'hA0, exp_req:1});
        vecs.push_back('{op:8'h00, addr:32'h0, wdata:32'h0, rdata:32'h0,
                         ack_dly:0, errm:0, late_ack:0, exp_status:8'hE3, exp_req:0});
        vecs.push_back('{op:8'h02, addr:32'hFFFF_FFFF, wdata:32'hFFFF_FFFF, rdata:32'h0,
                         ack_dly:14, errm:0, late_ack:0, exp_status:8'hA0, exp_req:15});
        vecs.push_back('{op:8'h01, addr:32'h0000_0ABC, wdata:32'h0, rdata:32'h55AA_00FF,
                         ack_dly:15, errm:0, late_ack:0, exp_status:8'hA0, exp_req:16});

        rst       = 1'b1;
        cmd       = '0;
        cmd_valid = 1'b0;
        dec_error = 1'b0;
        bus_ack   = 1'b0;
        bus_err   = 1'b0;
        bus_rdata = '0;
        tx_ready  = 1'b1;
        step();
        step();
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_dropped", {63'd0, cmd_dropped}, 64'd0);
        chk("rst_req", {63'd0, bus_req}, 64'd0);
        chk("rst_we", {63'd0, bus_we}, 64'd0);
        chk("rst_addr", 64'(bus_addr), 64'd0);
        chk("rst_wdata", 64'(bus_wdata), 64'd0);
        chk("rst_txv", {63'd0, tx_valid}, 64'd0);
        chk("rst_txd", 64'(tx_data), 64'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(i, vecs[i]);
        end

        // dec_error wins over a simultaneous command; dec_error alone also reports E4.
        push_resp(8'hE4, 8'h00, 32'h0, n);
        n0 = hs_total;
        send(8'h01, 32'h44, 32'h0, 1'b1, 1'b1);
        chk("dec_both_req", {63'd0, bus_req}, 64'd0);
        chk("dec_both_txv", {63'd0, tx_valid}, 64'd1);
        drain("dec_both");
        chk("dec_both_nbytes", 64'(hs_total - n0), 64'd1);
        push_resp(8'hE4, 8'h00, 32'h0, n);
        n0 = hs_total;
        send(8'h00, 32'h0, 32'h0, 1'b0, 1'b1);
        drain("dec_only");
        chk("dec_only_nbytes", 64'(hs_total - n0), 64'd1);
        chk("dropped_pre", {63'd0, cmd_dropped}, 64'd0);

        // Back-pressure on status and on a data byte, with a command dropped mid-response.
        tx_ready = 1'b0;
        push_resp(8'hA0, 8'h01, 32'hCAFE_F00D, n);
        n0 = hs_total;
        send(8'h01, 32'h20, 32'h0, 1'b1, 1'b0);
        bus_ack   = 1'b1;
        bus_rdata = 32'hCAFE_F00D;
        step();
        bus_ack   = 1'b0;
        held = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!(tx_valid === 1'b1 && tx_data === 8'hA0)) held = 1'b0;
            if (i == 2) begin
                cmd       = {8'h03, 64'h0};
                cmd_valid = 1'b1;
            end
            step();
            cmd_valid = 1'b0;
        end
        chk("hold_status", {63'd0, held}, 64'd1);
        chk("dropped_set", {63'd0, cmd_dropped}, 64'd1);
        tx_ready = 1'b1;
        step();
        step();
        tx_ready = 1'b0;
        held = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!(tx_valid === 1'b1 && tx_data === 8'hFE)) held = 1'b0;
            step();
        end
        chk("hold_data", {63'd0, held}, 64'd1);
        tx_ready = 1'b1;
        drain("bp");
        chk("bp_nbytes", 64'(hs_total - n0), 64'(n));
        step();
        step();
        chk("dropped_sticky", {63'd0, cmd_dropped}, 64'd1);
        chk("bp_no_extra", 64'(hs_total - n0), 64'(n));

        // Reset during a bus access aborts it with no response.
        send(8'h01, 32'h30, 32'h0, 1'b1, 1'b0);
        chk("abort_req_pre", {63'd0, bus_req}, 64'd1);
        step();
        n0 = hs_total;
        #2;
        rst = 1'b1;
        #1;
        chk("abort_req", {63'd0, bus_req}, 64'd0);
        chk("abort_txv", {63'd0, tx_valid}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_dropped", {63'd0, cmd_dropped}, 64'd0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("abort_no_resp", 64'(hs_total - n0), 64'd0);
        run_vec(99, vecs[5]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, required $finish");
        $fatal(1);
    end

endmodule

// File: doc/dbg_executor.md
# dbg_executor

Executes debug commands assembled by the UART debug decoder: it takes one decoded command word, runs the corresponding single-beat access on the debug bus, and streams a status byte plus any read data to the UART byte transmitter. It sits between the decoder (upstream), the system debug bus master port (side) and the UART TX byte interface (downstream). It owns sequencing, bus timeout and response framing.

## Interface
- `DatW`, 4: data width in bytes
- `AdrW`, 4: address width in bytes
- `BusTimeout`, 1024: max cycles `bus_req` may wait for `bus_ack`/`bus_err`, ≥2
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-high
- `cmd` in 8*(1+AdrW+DatW): command word {opcode[7:0], addr, wdata}, opcode in MSBs
- `cmd_valid` in 1: one-cycle pulse, `cmd` valid
- `dec_error` in 1: one-cycle pulse, decoder framing/timeout error
- `busy` out 1: high whenever state ≠ IDLE
- `cmd_dropped` out 1: sticky, a `cmd_valid`/`dec_error` pulse arrived while busy
- `bus_req` out 1: access request, held until `bus_ack` or `bus_err` or timeout
- `bus_we` out 1: 1 = write
- `bus_addr` out 8*AdrW: access address
- `bus_wdata` out 8*DatW: write data
- `bus_ack` in 1: access complete
- `bus_err` in 1: access failed
- `bus_rdata` in 8*DatW: read data, valid with `bus_ack`
- `tx_data` out 8: response byte
- `tx_valid` out 1: `tx_data` valid
- `tx_ready` in 1: transmitter accepts byte when `tx_valid & tx_ready`

## Operation
- Opcodes: 0x01 READ, 0x02 WRITE, 0x03 PING; any other → bad opcode.
- Status bytes: 0xA0 OK, 0xE1 bus error, 0xE2 bus timeout, 0xE3 bad opcode, 0xE4 decode error.
- States: IDLE, BUS, RESP_STATUS, RESP_DATA.
- IDLE: on `cmd_valid`, register cmd fields. READ/WRITE → BUS; PING → RESP_STATUS(0xA0); bad opcode → RESP_STATUS(0xE3). On `dec_error` (without `cmd_valid`) → RESP_STATUS(0xE4). Both in same cycle: `dec_error` wins, cmd discarded.
- BUS: `bus_req`=1, `bus_we`/`bus_addr`/`bus_wdata` stable from registered cmd. Timeout counter counts BUS cycles from 0. Exit on `bus_err` → 0xE1; else `bus_ack` → 0xA0 (READ captures `bus_rdata`); else counter = BusTimeout-1 → 0xE2. Priority same cycle: err > ack > timeout.
- RESP_STATUS: `tx_valid`=1, `tx_data`=status. On handshake: READ with OK → RESP_DATA; else → IDLE.
- RESP_DATA: DatW bytes of captured read data, MSB byte first; byte counter 0..DatW-1; after last handshake → IDLE.
- `cmd_valid`/`dec_error` pulses outside IDLE are dropped, set `cmd_dropped`; only `rst` clears it.
- Write data and addr never change while `bus_req`=1.

## Timing
- Reset values: `busy`=0, `cmd_dropped`=0, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, `tx_valid`=0, `tx_data`=0; state IDLE, counters 0. Asserting `rst` mid-transaction drops `bus_req`/`tx_valid` asynchronously; no response is sent for the aborted command.
- Cycle 0 `cmd_valid` → cycle 1 `bus_req`=1 (or `tx_valid`=1 for PING/bad opcode/decode error).
- `bus_ack` in cycle n → `bus_req`=0 and `tx_valid`=1 in cycle n+1; zero-wait ack (ack in cycle 1) allowed.
- Timeout: with no ack, `bus_req` high exactly BusTimeout cycles, then `tx_valid`=1 with 0xE2 in following cycle.
- `tx_valid` held, `tx_data` stable until handshake; next byte presented the cycle after handshake (back-to-back with `tx_ready` held high: one byte per cycle).
- `bus_ack` arriving after timeout is ignored.
- `busy` falls the cycle after final handshake; new `cmd_valid` accepted that cycle.

## Test plan
- READ addr 0x00001000, `bus_ack` after 3 cycles with rdata 0xDEADBEEF, `tx_ready`=1 → bytes A0,DE,AD,BE,EF on consecutive cycles, `bus_we`=0.
- WRITE addr 0x10, data 0x12345678, zero-wait ack → `bus_req` one cycle, `bus_we`=1, wdata 0x12345678; response A0 only.
- READ with no ack, BusTimeout=16 → `bus_req` high 16 cycles, response E2; late ack ignored; `bus_err` and `bus_ack` together → E1.
- Opcode 0x7F → E3 with no `bus_req`; PING → A0; `dec_error` and `cmd_valid` same cycle → E4 only.
- `tx_ready` low for 5 cycles during READ response → `tx_valid`/`tx_data` held, no byte lost or duplicated; `cmd_valid` during response → dropped, `cmd_dropped`=1.
- `rst` asserted while `bus_req`=1 → `bus_req`, `tx_valid`, `busy` 0 immediately; after release, new PING → A0.
